// File: rtl/neuro_timer_pkg.sv
// Shared types and helpers for the delay scheduler: FSM state encoding,
// default sizing, and the round-robin arbitration function.
package neuro_timer_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Returns the first set bit of req searching upward from last+1 with
   // wrap-around over n requesters (n <= 8). Returns last when req is empty.
   // The loop runs from the farthest candidate to the nearest so the nearest
   // match is the one that sticks.
   function automatic int rr_pick(input logic [7:0] req, input int n, input int last);
      int idx;
      rr_pick = last;
      for (int k = 8; k >= 1; k--) begin
         if (k <= n) begin
            idx = (last + k) % n;
            if (req[idx]) rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/mod_numCounter.sv
// Shared 16-bit-style down-counter. A load (which also serves as its reset)
// takes inVal; a decrement request is honoured only while the count is
// nonzero, so the value never wraps below zero.
module mod_numCounter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] inVal,
   output logic [W-1:0] count_o,
   output logic         isZero
);

   logic [W-1:0] cnt_q;

   // Load has priority over decrement; decrement saturates at zero.
   always_ff @(posedge clk_i) begin
      if (load_i) begin
         cnt_q <= inVal;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign count_o = cnt_q;
   assign isZero  = (cnt_q == '0);

endmodule

// File: rtl/delay_scheduler.sv
// Time-shares one down-counter between N_REQ requesters. Each request is
// granted round-robin, the winner's delay is loaded and counted down on
// timebase ticks, then a one-cycle done pulse goes back to that requester.
//
// Handshake: req[i] is a level held high until the one-cycle ack[i] pulse;
// delay[i*W +: W] must be stable while req[i] is high. Dropping req[i] after
// ack has no effect on the delay already in flight. done[i] is a one-cycle
// pulse with no back-pressure. ack and done are one-hot and never coincide.
module delay_scheduler
   import neuro_timer_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] delay,
   input  logic               abort,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   done,
   output logic               busy,
   output logic [IDW-1:0]     grant_id,
   output logic [W-1:0]       remaining,
   output state_e             state_o
);

   state_e           state_q, state_d;
   logic [W-1:0]     dly_q, dly_d;
   logic [IDW-1:0]   gid_q, gid_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   pick;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             busy_q, busy_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [W-1:0]     cnt_in, cnt_val;

   assign pick = IDW'(rr_pick(8'(req), N_REQ, int'(last_q)));

   // Next-state and registered-output logic; every output is a flop loaded
   // from its _d value, so outputs change one edge after the decision.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      gid_d   = gid_q;
      last_d  = last_q;
      ack_d   = '0;
      done_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               dly_d       = delay[int'(pick)*W +: W];
               gid_d       = pick;
               ack_d[pick] = 1'b1;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               last_d  = gid_q;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            // abort outranks expiry: a cancelled delay never reports done
            if (abort) begin
               last_d  = gid_q;
               state_d = ST_IDLE;
            end else if (cnt_zero) begin
               done_d[gid_q] = 1'b1;
               state_d       = ST_DONE;
            end
         end
         ST_DONE: begin
            last_d  = gid_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset; last grant resets to
   // the top index so requester 0 wins the first arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dly_q   <= '0;
         gid_q   <= '0;
         last_q  <= IDW'(N_REQ - 1);
         ack_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Reset reuses the counter's load path with a zero value.
   assign cnt_in   = rst ? '0 : dly_q;
   assign cnt_load = rst | (state_q == ST_LOAD);
   assign cnt_dec  = (state_q == ST_COUNT) & tick & ~cnt_zero;

   mod_numCounter #(.W(W)) u_counter (
      .clk_i  (clk),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .inVal  (cnt_in),
      .count_o(cnt_val),
      .isZero (cnt_zero)
   );

   assign ack       = ack_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign grant_id  = gid_q;
   assign remaining = cnt_val;
   assign state_o   = state_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler. Edges are numbered by cyc; the
// tick value sampled at edge e is tick_at(e), so the expected done edge and
// remaining trace of every grant are derived from the delay and the tick
// pattern alone. Grant order comes from a round-robin model over req.
module tb_delay_scheduler;
   import neuro_timer_pkg::*;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           tick;
   logic [N-1:0]   req;
   logic [N*W-1:0] delay;
   logic           abort;
   logic [N-1:0]   ack, done;
   logic           busy;
   logic [IDW-1:0] grant_id;
   logic [W-1:0]   remaining;
   state_e         state_o;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int tick_mode = 0;
   bit rand_tick [1024];
   int lg;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   // observations of one transaction
   logic [N-1:0]   o_ack, o_done;
   logic [IDW-1:0] o_gid;
   int             o_ack_e, o_done_e;
   logic           o_busy_after, o_done_after;
   bit             o_stray;

   delay_scheduler #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .tick(tick), .req(req), .delay(delay), .abort(abort),
      .ack(ack), .done(done), .busy(busy), .grant_id(grant_id),
      .remaining(remaining), .state_o(state_o)
   );

   // ---------------- clock / edge counter / tick driver ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit tick_at(input int e);
      case (tick_mode)
         0:       return 1'b1;
         1:       return (e % 3) == 0;
         default: return rand_tick[e % 1024];
      endcase
   endfunction

   initial begin
      tick = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tick = tick_at(cyc + 1);
      end
   end

   // ---------------- reference model ----------------
   function automatic int pick_model(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   // Load at ack+1; then d ticks must be seen; done one edge after the last.
   function automatic int exp_done_edge(input int a, input int d);
      int z, n;
      z = a + 1;
      n = 0;
      while (n < d) begin
         z++;
         if (tick_at(z)) n++;
      end
      return z + 1;
   endfunction

   // Expected remaining at each edge from ack+1 through the done edge.
   function automatic void build_exp(input int a, input int d, input int de);
      int v;
      exp_q.delete();
      v = d;
      for (int e = a + 1; e <= de; e++) begin
         if (e >= a + 2 && tick_at(e) && v > 0) v--;
         exp_q.push_back(W'(v));
      end
   endfunction

   // ---------------- driver / observer ----------------
   task automatic collect(input int max_cyc, input bit drop_req);
      o_ack = '0; o_done = '0; o_gid = '0; o_ack_e = -1; o_done_e = -1;
      o_busy_after = 1'b1; o_done_after = 1'b1; o_stray = 1'b0;
      obs_q.delete();
      for (int k = 0; k < max_cyc; k++) begin
         @(posedge clk); #1;
         if (ack !== '0 && done !== '0) o_stray = 1'b1;
         if (o_ack_e < 0) begin
            if (ack !== '0) begin
               o_ack = ack; o_ack_e = cyc; o_gid = grant_id;
               if (drop_req)
                  for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
            end
         end else begin
            obs_q.push_back(remaining);
            if (ack !== '0) o_stray = 1'b1;
            if (done !== '0) begin
               o_done = done; o_done_e = cyc;
               @(posedge clk); #1;
               o_busy_after = busy; o_done_after = |done;
               break;
            end
         end
      end
   endtask

   function automatic bit trace_bad();
      bit bad;
      bad = (exp_q.size() != obs_q.size());
      foreach (exp_q[i]) if (i < obs_q.size() && obs_q[i] !== exp_q[i]) bad = 1'b1;
      return bad;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; req = '0; abort = 1'b0; delay = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({ack, done, busy, grant_id, remaining} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: ack=%b done=%b busy=%b gid=%0d rem=%0d, want all 0",
                  ack, done, busy, grant_id, remaining);
      end
      tests++;
      if (state_o !== ST_IDLE) begin
         fails++; $display("FAIL reset_state: got %0d want IDLE", state_o);
      end
      rst = 1'b0;
      lg  = N - 1;
   endtask

   task automatic test_single();
      int g;
      tick_mode = 0;
      delay[0*W +: W] = 16'd5;
      req = 4'b0001;
      g = pick_model(req, lg);
      collect(60, 1'b1);
      build_exp(o_ack_e, 5, o_done_e);
      tests++;
      if (o_ack !== N'(1 << g) || o_gid !== IDW'(g)) begin
         fails++; $display("FAIL single_ack: ack=%b gid=%0d want g=%0d", o_ack, o_gid, g);
      end
      tests++;
      if (o_done_e - o_ack_e != 7 || o_done !== N'(1 << g)) begin
         fails++; $display("FAIL single_latency: done=%b after %0d, want %b after 7",
                           o_done, o_done_e - o_ack_e, N'(1 << g));
      end
      tests++;
      if (trace_bad()) begin
         fails++; $display("FAIL single_remaining: got %p want %p", obs_q, exp_q);
      end
      tests++;
      if (o_busy_after !== 1'b0 || o_done_after !== 1'b0 || o_stray) begin
         fails++; $display("FAIL single_tail: busy=%b done=%b stray=%b, want 0 0 0",
                           o_busy_after, o_done_after, o_stray);
      end
      lg = g;
   endtask

   task automatic test_round_robin();
      int g;
      for (int i = 0; i < N; i++) delay[i*W +: W] = 16'd2;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         g = pick_model(req, lg);
         collect(60, 1'b0);
         tests++;
         if (o_ack !== N'(1 << g) || o_gid !== IDW'(g) || o_done !== N'(1 << g)) begin
            fails++; $display("FAIL rr_order[%0d]: ack=%b done=%b gid=%0d want g=%0d",
                              t, o_ack, o_done, o_gid, g);
         end
         tests++;
         if (o_done_e - o_ack_e != 4 || o_stray) begin
            fails++; $display("FAIL rr_latency[%0d]: got %0d stray=%b want 4 stray=0",
                              t, o_done_e - o_ack_e, o_stray);
         end
         lg = g;
         if (t == 4) req = '0;
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_zero_delay();
      int g;
      delay[1*W +: W] = 16'd0;
      req = 4'b0010;
      g = pick_model(req, lg);
      collect(60, 1'b1);
      build_exp(o_ack_e, 0, o_done_e);
      tests++;
      if (o_done !== N'(1 << g) || o_done_e - o_ack_e != 2 || o_gid !== IDW'(g)) begin
         fails++; $display("FAIL zero_delay: done=%b after %0d gid=%0d, want g=%0d after 2",
                           o_done, o_done_e - o_ack_e, o_gid, g);
      end
      tests++;
      if (trace_bad()) begin
         fails++; $display("FAIL zero_remaining: got %p want %p", obs_q, exp_q);
      end
      lg = g;
   endtask

   task automatic test_sparse_tick();
      int g;
      tick_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      delay[0*W +: W] = 16'd3;
      req = 4'b0001;
      g = pick_model(req, lg);
      collect(80, 1'b1);
      build_exp(o_ack_e, 3, o_done_e);
      tests++;
      if (o_done !== N'(1 << g) || o_done_e != exp_done_edge(o_ack_e, 3)) begin
         fails++; $display("FAIL sparse_done: done=%b at +%0d, want %b at +%0d", o_done,
                           o_done_e - o_ack_e, N'(1 << g), exp_done_edge(o_ack_e, 3) - o_ack_e);
      end
      tests++;
      if (trace_bad()) begin
         fails++; $display("FAIL sparse_remaining: got %p want %p", obs_q, exp_q);
      end
      lg = g;
      tick_mode = 0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int a, g, d3;
      bit seen_done;
      delay[2*W +: W] = 16'd10;
      req = 4'b0100;
      a = -1;
      for (int k = 0; k < 20 && a < 0; k++) begin
         @(posedge clk); #1;
         if (ack !== '0) begin a = cyc; req = '0; end
      end
      tests++;
      if (a < 0 || grant_id !== 2'd2) begin
         fails++; $display("FAIL abort_grant: ack_edge=%0d gid=%0d want gid=2", a, grant_id);
      end
      for (int k = 0; k < 20 && remaining !== 16'd6; k++) begin
         @(posedge clk); #1;
      end
      tests++;
      if (remaining !== 16'd6 || cyc - a != 5) begin
         fails++; $display("FAIL abort_reach6: rem=%0d at +%0d, want 6 at +5", remaining, cyc - a);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      tests++;
      if (state_o !== ST_IDLE || busy !== 1'b0 || done !== '0) begin
         fails++; $display("FAIL abort_idle: state=%0d busy=%b done=%b want IDLE 0 0",
                           state_o, busy, done);
      end
      lg = 2;
      seen_done = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done !== '0) seen_done = 1'b1;
      end
      tests++;
      if (seen_done) begin
         fails++; $display("FAIL abort_no_done: got a done pulse, want none");
      end
      d3 = $urandom_range(0, 7);
      delay[3*W +: W] = W'(d3);
      req = 4'b1000;
      g = pick_model(req, lg);
      collect(60, 1'b1);
      tests++;
      if (o_ack !== N'(1 << g) || o_done !== N'(1 << g) || o_done_e - o_ack_e != d3 + 2) begin
         fails++; $display("FAIL abort_next: ack=%b done=%b lat=%0d want g=%0d lat=%0d",
                           o_ack, o_done, o_done_e - o_ack_e, g, d3 + 2);
      end
      lg = g;
   endtask

   task automatic test_reset_mid();
      int a, g;
      delay[0*W +: W] = 16'd8;
      req = 4'b0001;
      a = -1;
      for (int k = 0; k < 20 && a < 0; k++) begin
         @(posedge clk); #1;
         if (ack !== '0) begin a = cyc; req = '0; end
      end
      for (int k = 0; k < 20 && remaining !== 16'd4; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({ack, done, busy, grant_id, remaining} !== '0 || state_o !== ST_IDLE) begin
         fails++; $display("FAIL midreset_outputs: ack=%b done=%b busy=%b gid=%0d rem=%0d st=%0d",
                           ack, done, busy, grant_id, remaining, state_o);
      end
      rst = 1'b0;
      lg  = N - 1;
      delay[0*W +: W] = 16'd2;
      delay[3*W +: W] = 16'd1;
      req = 4'b1001;
      g = pick_model(req, lg);
      collect(60, 1'b1);
      tests++;
      if (o_ack !== N'(1 << g) || o_gid !== IDW'(g) || o_done_e - o_ack_e != 4) begin
         fails++; $display("FAIL midreset_first: ack=%b gid=%0d lat=%0d want g=%0d lat=4",
                           o_ack, o_gid, o_done_e - o_ack_e, g);
      end
      lg = g;
      req = '0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int g, d;
      logic [N-1:0] snap;
      tick_mode = 2;
      repeat (3) @(posedge clk);
      #1;
      for (int t = 0; t < 24; t++) begin
         if (req == '0) begin
            for (int i = 0; i < N; i++) delay[i*W +: W] = W'($urandom_range(0, 10));
            req = N'($urandom_range(1, (1 << N) - 1));
         end
         snap = req;
         g = pick_model(snap, lg);
         d = int'(delay[g*W +: W]);
         collect(300, 1'b1);
         build_exp(o_ack_e, d, o_done_e);
         tests++;
         if (o_ack !== N'(1 << g) || o_gid !== IDW'(g) || o_done !== N'(1 << g)) begin
            fails++; $display("FAIL rand_grant[%0d]: req=%b ack=%b done=%b gid=%0d want g=%0d",
                              t, snap, o_ack, o_done, o_gid, g);
         end
         tests++;
         if (o_done_e != exp_done_edge(o_ack_e, d) || trace_bad() || o_stray || o_busy_after) begin
            fails++; $display("FAIL rand_timing[%0d]: d=%0d done at +%0d want +%0d stray=%b busy=%b",
                              t, d, o_done_e - o_ack_e, exp_done_edge(o_ack_e, d) - o_ack_e,
                              o_stray, o_busy_after);
         end
         lg = g;
      end
      req = '0;
      tick_mode = 0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      for (int i = 0; i < 1024; i++) rand_tick[i] = 1'($urandom_range(0, 1));
      test_reset();
      test_single();
      test_round_robin();
      test_zero_delay();
      test_sparse_tick();
      test_abort();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
